// File: rtl/regset6_exec_ctrl_pkg.sv
// Shared constants, opcodes, FSM states and instruction layout
// for the regset6 execute/writeback controller.
package regset6_pkg;

  localparam int DATA_W  = 4;
  localparam int NREGS   = 6;
  localparam int IDX_W   = 3;
  localparam int OP_W    = 3;

  localparam int OP_LSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RA_LSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LDI  = 3'd5,
    OP_ADDI = 3'd6,
    OP_NOP  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  ra;
    logic [IDX_W-1:0]  rb;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic logic bad_idx(
    input logic [IDX_W-1:0] i
  );
    return i >= IDX_W'(NREGS);
  endfunction

  // rd is always checked; ra/rb only where the op reads them
  function automatic logic illegal(
    input instr_t i
  );
    logic use_ra;
    logic use_rb;
    use_ra = !(i.op inside {OP_LDI, OP_NOP});
    use_rb = i.op inside {OP_ADD, OP_SUB,
                          OP_AND, OP_OR,
                          OP_XOR};
    return bad_idx(i.rd)
        || (use_ra && bad_idx(i.ra))
        || (use_rb && bad_idx(i.rb));
  endfunction

endpackage

// File: rtl/regset6_exec_ctrl_if.sv
// Instruction handshake plus register-set
// read/write bus seen by the controller.
interface regset6_exec_ctrl_if;
  import regset6_pkg::*;

  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic [IDX_W-1:0]  RA;
  logic [IDX_W-1:0]  RB;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [IDX_W-1:0]  WR;
  logic [DATA_W-1:0] WRD;
  logic              Reg_EN;
  logic              done;
  logic              err;
  logic              carry;
  logic              zero;

  modport slave (
    input  instr_valid, instr, A, B,
    output instr_ready, RA, RB,
    output WR, WRD, Reg_EN,
    output done, err, carry, zero
  );

  modport master (
    output instr_valid, instr, A, B,
    input  instr_ready, RA, RB,
    input  WR, WRD, Reg_EN,
    input  done, err, carry, zero
  );

endinterface

// File: rtl/regset6_exec_ctrl_alu4.sv
// 4-bit combinational ALU; carry is bit 4 of a
// 5-bit sum, so logic ops report carry=0.
module alu4
  import regset6_pkg::*;
(
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    unique case (op_i)
      OP_ADD:  sum = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  sum = {1'b0, a_i} + {1'b0, ~b_i}
                   + (DATA_W+1)'(1);
      OP_AND:  sum = {1'b0, a_i & b_i};
      OP_OR:   sum = {1'b0, a_i | b_i};
      OP_XOR:  sum = {1'b0, a_i ^ b_i};
      OP_LDI:  sum = {1'b0, imm_i};
      OP_ADDI: sum = {1'b0, a_i} + {1'b0, imm_i};
      OP_NOP:  sum = '0;
    endcase
    result_o = sum[DATA_W-1:0];
    carry_o  = sum[DATA_W];
    zero_o   = (sum[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/regset6_exec_ctrl.sv
// Four-state execute/writeback controller in front of
// the 6x4 register set; every output is a flop.
module regset6_exec_ctrl
  import regset6_pkg::*;
(
  input logic               clock,
  input logic               reset_n,
  regset6_exec_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  instr_t            ins_q, ins_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              cres_q, cres_d;
  logic              zres_q, zres_d;
  logic              rdy_q, rdy_d;
  logic [IDX_W-1:0]  ra_q, ra_d, rb_q, rb_d;
  logic [IDX_W-1:0]  wr_q, wr_d;
  logic [DATA_W-1:0] wrd_q, wrd_d;
  logic              ren_q, ren_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cy_q, cy_d;
  logic              zf_q, zf_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_z;
  logic              ill;

  alu4 u_alu (
    .op_i     (ins_q.op),
    .a_i      (a_q),
    .b_i      (b_q),
    .imm_i    (ins_q.imm),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  assign ill = illegal(ins_q);

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    a_d     = a_q;
    b_d     = b_q;
    cres_d  = cres_q;
    zres_d  = zres_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wr_d    = wr_q;
    wrd_d   = wrd_q;
    ren_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cy_d    = cy_q;
    zf_d    = zf_q;
    unique case (state_q)
      S_IDLE: begin
        // rdy_q also masks the first cycle after reset
        if (rdy_q && bus.instr_valid) begin
          state_d   = S_READ;
          ins_d.op  = op_e'(bus.instr[OP_LSB +: OP_W]);
          ins_d.rd  = bus.instr[RD_LSB +: IDX_W];
          ins_d.ra  = bus.instr[RA_LSB +: IDX_W];
          ins_d.rb  = bus.instr[RB_LSB +: IDX_W];
          ins_d.imm = bus.instr[IMM_LSB +: DATA_W];
          ra_d      = ins_d.ra;
          rb_d      = ins_d.rb;
        end
      end
      S_READ: begin
        a_d     = bus.A;
        b_d     = bus.B;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        done_d  = 1'b1;
        err_d   = ill;
        ren_d   = !ill && (ins_q.op != OP_NOP);
        cres_d  = alu_c;
        zres_d  = alu_z;
        if (ren_d) begin
          wr_d  = ins_q.rd;
          wrd_d = alu_res;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (ren_q) begin
          cy_d = cres_q;
          zf_d = zres_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ins_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cres_q <= 1'b0;
      zres_q <= 1'b0;
      rdy_q  <= 1'b0;
      ra_q   <= '0;
      rb_q   <= '0;
      wr_q   <= '0;
      wrd_q  <= '0;
      ren_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cy_q   <= 1'b0;
      zf_q   <= 1'b0;
    end else begin
      ins_q  <= ins_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cres_q <= cres_d;
      zres_q <= zres_d;
      rdy_q  <= rdy_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      wr_q   <= wr_d;
      wrd_q  <= wrd_d;
      ren_q  <= ren_d;
      done_q <= done_d;
      err_q  <= err_d;
      cy_q   <= cy_d;
      zf_q   <= zf_d;
    end
  end

  assign bus.instr_ready = rdy_q;
  assign bus.RA          = ra_q;
  assign bus.RB          = rb_q;
  assign bus.WR          = wr_q;
  assign bus.WRD         = wrd_q;
  assign bus.Reg_EN      = ren_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.carry       = cy_q;
  assign bus.zero        = zf_q;

endmodule
